// File: rtl/sync_arith_pkg.sv
// Shared types and constants for the arbitrated arithmetic-unit front end.
package sync_arith_pkg;

    localparam int unsigned STATUS_W = 4;
    localparam int unsigned OP_W     = 2;

    typedef logic [OP_W-1:0] op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, with wrap-around.
module rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             found
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        // Search order starts one past the last winner so it ends up with lowest priority.
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/sync_arith_unit_arbiter.sv
// Shares one external fixed-latency ALU between NREQ requesters with
// round-robin arbitration and valid/ready request and response handshakes.
module sync_arith_unit_arbiter
    import sync_arith_pkg::*;
#(
    parameter int unsigned BITS    = 32,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NREQ-1:0]        i_req_valid,
    input  logic [NREQ*BITS-1:0]   i_req_A,
    input  logic [NREQ*BITS-1:0]   i_req_B,
    input  logic [NREQ*OP_W-1:0]   i_req_op,
    output logic [NREQ-1:0]        o_req_ready,
    output logic [NREQ-1:0]        o_rsp_valid,
    input  logic [NREQ-1:0]        i_rsp_ready,
    output logic [BITS-1:0]        o_rsp_result,
    output logic [STATUS_W-1:0]    o_rsp_status,
    output logic [BITS-1:0]        o_alu_arg_A,
    output logic [BITS-1:0]        o_alu_arg_B,
    output logic [OP_W-1:0]        o_alu_op,
    input  logic [BITS-1:0]        i_alu_result,
    input  logic [STATUS_W-1:0]    i_alu_status,
    output logic                   o_busy
);

    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned CNT_W = $clog2(ALU_LAT + 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BITS-1:0]     alu_a_q, alu_a_d;
    logic [BITS-1:0]     alu_b_q, alu_b_d;
    op_t                 alu_op_q, alu_op_d;
    logic [BITS-1:0]     res_q, res_d;
    logic [STATUS_W-1:0] st_q, st_d;
    logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic                busy_q, busy_d;

    logic [NREQ-1:0]     grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                found;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req       (i_req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .found     (found)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        res_d       = res_q;
        st_d        = st_q;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    alu_a_d  = i_req_A[32'(grant_idx) * BITS +: BITS];
                    alu_b_d  = i_req_B[32'(grant_idx) * BITS +: BITS];
                    alu_op_d = i_req_op[32'(grant_idx) * OP_W +: OP_W];
                    owner_d  = grant_idx;
                    ptr_d    = grant_idx;
                    cnt_d    = CNT_W'(ALU_LAT);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    res_d                = i_alu_result;
                    st_d                 = i_alu_status;
                    rsp_valid_d          = '0;
                    rsp_valid_d[owner_q] = 1'b1;
                    state_d              = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                // Only the owner's ready completes the response.
                if (i_rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = '0;
                state_d     = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            ptr_q       <= IDX_W'(NREQ - 1);
            owner_q     <= '0;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_q       <= '0;
            st_q        <= '0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_q       <= res_d;
            st_q        <= st_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Accept is offered combinationally so a requester can be taken in the same cycle.
    assign o_req_ready  = (state_q == IDLE) ? grant : '0;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_result = res_q;
    assign o_rsp_status = st_q;
    assign o_alu_arg_A  = alu_a_q;
    assign o_alu_arg_B  = alu_b_q;
    assign o_alu_op     = alu_op_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_sync_arith_unit_arbiter.sv
// Bench for sync_arith_unit_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level timing model, using stub XOR ALUs.
module tb_sync_arith_unit_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [127:0] req_a, req_b;
    logic [7:0]   req_op;
    logic [31:0]  rsp_result, alu_a, alu_b, alu_result;
    logic [3:0]   rsp_status, alu_status;
    logic [1:0]   alu_op;
    logic         busy;

    logic [3:0]   req_valid3, req_ready3, rsp_valid3, rsp_ready3;
    logic [127:0] req_a3, req_b3;
    logic [7:0]   req_op3;
    logic [31:0]  rsp_result3, alu_a3, alu_b3, alu_result3;
    logic [3:0]   rsp_status3, alu_status3;
    logic [1:0]   alu_op3;
    logic         busy3;

    logic [31:0]  p3_res [3];
    logic [3:0]   p3_st  [3];

    int n_checks = 0;
    int n_fail   = 0;

    sync_arith_unit_arbiter #(.BITS(32), .NREQ(4), .ALU_LAT(1)) u_dut (
        .i_clk(clk), .i_reset(reset),
        .i_req_valid(req_valid), .i_req_A(req_a), .i_req_B(req_b), .i_req_op(req_op),
        .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_result(rsp_result), .o_rsp_status(rsp_status),
        .o_alu_arg_A(alu_a), .o_alu_arg_B(alu_b), .o_alu_op(alu_op),
        .i_alu_result(alu_result), .i_alu_status(alu_status), .o_busy(busy)
    );

    sync_arith_unit_arbiter #(.BITS(32), .NREQ(4), .ALU_LAT(3)) u_dut3 (
        .i_clk(clk), .i_reset(reset),
        .i_req_valid(req_valid3), .i_req_A(req_a3), .i_req_B(req_b3), .i_req_op(req_op3),
        .o_req_ready(req_ready3), .o_rsp_valid(rsp_valid3), .i_rsp_ready(rsp_ready3),
        .o_rsp_result(rsp_result3), .o_rsp_status(rsp_status3),
        .o_alu_arg_A(alu_a3), .o_alu_arg_B(alu_b3), .o_alu_op(alu_op3),
        .i_alu_result(alu_result3), .i_alu_status(alu_status3), .o_busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub ALUs: result = A ^ B, status = {2'b00, op}, latency 1 and 3.
    always @(posedge clk) begin
        alu_result <= alu_a ^ alu_b;
        alu_status <= {2'b00, alu_op};
        p3_res[0]  <= alu_a3 ^ alu_b3;
        p3_res[1]  <= p3_res[0];
        p3_res[2]  <= p3_res[1];
        p3_st[0]   <= {2'b00, alu_op3};
        p3_st[1]   <= p3_st[0];
        p3_st[2]   <= p3_st[1];
    end
    assign alu_result3 = p3_res[2];
    assign alu_status3 = p3_st[2];

    task automatic apply_reset();
        req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_op = '0;
        req_valid3 = '0; rsp_ready3 = '0; req_a3 = '0; req_b3 = '0; req_op3 = '0;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        n_checks++; if (rsp_valid !== 4'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
        n_checks++; if ({rsp_result, rsp_status, alu_a, alu_b, alu_op} !== '0) begin
            n_fail++; $display("FAIL reset_regs: got %h %h %h %h %h expected all 0", rsp_result, rsp_status, alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_single_op();
        logic [3:0] exp_v;
        apply_reset();
        rsp_ready = 4'hF;
        req_a[31:0] = 32'h0000_00F0; req_b[31:0] = 32'h0000_000F; req_op[1:0] = 2'd2;
        req_valid = 4'b0001;
        @(negedge clk);
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1 req_valid = '0;
            @(negedge clk);
            exp_v = (c == 3) ? 4'b0001 : 4'b0000;
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy c%0d: got %b expected 1", c, busy); end
            n_checks++; if (rsp_valid !== exp_v) begin n_fail++; $display("FAIL single_rsp_valid c%0d: got %b expected %b", c, rsp_valid, exp_v); end
            if (c == 3) begin
                n_checks++; if (rsp_result !== 32'h0000_00FF) begin n_fail++; $display("FAIL single_result: got %h expected 000000ff", rsp_result); end
                n_checks++; if (rsp_status !== 4'h2) begin n_fail++; $display("FAIL single_status: got %h expected 2", rsp_status); end
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_all_four();
        int gcyc[$];
        int gidx[$];
        int idx;
        apply_reset();
        rsp_ready = 4'hF;
        for (int j = 0; j < 4; j++) begin
            req_a[j*32 +: 32] = $urandom; req_b[j*32 +: 32] = $urandom; req_op[j*2 +: 2] = 2'($urandom);
        end
        req_valid = 4'hF;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            if (req_ready !== 4'b0) begin
                idx = -1;
                for (int j = 0; j < 4; j++) if (req_ready[j]) idx = j;
                gcyc.push_back(c);
                gidx.push_back(idx);
            end
        end
        n_checks++; if (gcyc.size() !== 5) begin n_fail++; $display("FAIL rr_grant_count: got %0d expected 5", gcyc.size()); end
        for (int k = 0; k < gcyc.size() && k < 5; k++) begin
            n_checks++; if (gcyc[k] !== 4*k) begin n_fail++; $display("FAIL rr_grant_cycle %0d: got %0d expected %0d", k, gcyc[k], 4*k); end
            n_checks++; if (gidx[k] !== k % 4) begin n_fail++; $display("FAIL rr_grant_idx %0d: got %0d expected %0d", k, gidx[k], k % 4); end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b;
        logic [1:0]  op;
        logic [3:0]  exp_v, exp_r;
        apply_reset();
        a = $urandom; b = $urandom; op = 2'($urandom);
        req_a[63:32] = a; req_b[63:32] = b; req_op[3:2] = op;
        req_valid = 4'b0010;
        rsp_ready = 4'b1101;
        @(negedge clk);
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_first_ready: got %b expected 0010", req_ready); end
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            if (c == 8) rsp_ready = 4'b1111;
            @(negedge clk);
            exp_v = (c >= 3 && c <= 8) ? 4'b0010 : 4'b0000;
            exp_r = (c == 9) ? 4'b0010 : 4'b0000;
            n_checks++; if (rsp_valid !== exp_v) begin n_fail++; $display("FAIL bp_rsp_valid c%0d: got %b expected %b", c, rsp_valid, exp_v); end
            n_checks++; if (req_ready !== exp_r) begin n_fail++; $display("FAIL bp_ready c%0d: got %b expected %b", c, req_ready, exp_r); end
            if (c >= 3 && c <= 8) begin
                n_checks++; if (rsp_result !== (a ^ b)) begin n_fail++; $display("FAIL bp_result c%0d: got %h expected %h", c, rsp_result, a ^ b); end
                n_checks++; if (rsp_status !== {2'b00, op}) begin n_fail++; $display("FAIL bp_status c%0d: got %h expected %h", c, rsp_status, {2'b00, op}); end
            end
        end
        req_valid = '0;
    endtask

    task automatic test_reset_in_exec();
        apply_reset();
        rsp_ready = 4'hF;
        req_a[63:32] = $urandom | 32'h1; req_b[63:32] = $urandom; req_op[3:2] = 2'd3;
        req_valid = 4'b0010;
        @(negedge clk);
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rex_ready: got %b expected 0010", req_ready); end
        @(posedge clk); #1 req_valid = '0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rex_busy_before: got %b expected 1", busy); end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_checks++; if ({busy, rsp_valid, req_ready} !== 9'b0) begin
            n_fail++; $display("FAIL rex_ctrl_zero: got busy=%b rsp_valid=%b ready=%b expected 0", busy, rsp_valid, req_ready);
        end
        n_checks++; if ({rsp_result, rsp_status, alu_a, alu_b, alu_op} !== '0) begin
            n_fail++; $display("FAIL rex_data_zero: got %h %h %h %h %h expected all 0", rsp_result, rsp_status, alu_a, alu_b, alu_op);
        end
        for (int c = 4; c <= 8; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++; if (rsp_valid !== 4'b0) begin n_fail++; $display("FAIL rex_no_rsp c%0d: got %b expected 0000", c, rsp_valid); end
        end
        @(posedge clk); #1 req_valid = 4'hF;
        @(negedge clk);
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rex_next_grant: got %b expected 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single_requester();
        logic [3:0] exp_r;
        apply_reset();
        rsp_ready = 4'hF;
        req_a[95:64] = $urandom; req_b[95:64] = $urandom; req_op[5:4] = 2'($urandom);
        req_valid = 4'b0100;
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            exp_r = (c % 4 == 0) ? 4'b0100 : 4'b0000;
            n_checks++; if (req_ready !== exp_r) begin n_fail++; $display("FAIL solo_ready c%0d: got %b expected %b", c, req_ready, exp_r); end
            if (c % 4 == 3) begin
                n_checks++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL solo_rsp c%0d: got %b expected 0100", c, rsp_valid); end
            end
        end
        req_valid = '0;
    endtask

    task automatic test_lat3();
        logic [31:0] a, b;
        logic [1:0]  op;
        logic [3:0]  exp_v;
        apply_reset();
        a = $urandom; b = $urandom; op = 2'($urandom);
        req_a3[31:0] = a; req_b3[31:0] = b; req_op3[1:0] = op;
        rsp_ready3 = 4'hF;
        req_valid3 = 4'b0001;
        @(negedge clk);
        n_checks++; if (req_ready3 !== 4'b0001) begin n_fail++; $display("FAIL lat3_ready: got %b expected 0001", req_ready3); end
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1 req_valid3 = '0;
            @(negedge clk);
            exp_v = (c == 5) ? 4'b0001 : 4'b0000;
            n_checks++; if (busy3 !== (c <= 5)) begin n_fail++; $display("FAIL lat3_busy c%0d: got %b expected %b", c, busy3, c <= 5); end
            n_checks++; if (rsp_valid3 !== exp_v) begin n_fail++; $display("FAIL lat3_rsp_valid c%0d: got %b expected %b", c, rsp_valid3, exp_v); end
            if (c == 1) begin
                n_checks++; if (alu_a3 !== a) begin n_fail++; $display("FAIL lat3_alu_a: got %h expected %h", alu_a3, a); end
            end
            if (c == 5) begin
                n_checks++; if (rsp_result3 !== (a ^ b)) begin n_fail++; $display("FAIL lat3_result: got %h expected %h", rsp_result3, a ^ b); end
                n_checks++; if (rsp_status3 !== {2'b00, op}) begin n_fail++; $display("FAIL lat3_status: got %h expected %h", rsp_status3, {2'b00, op}); end
            end
        end
    endtask

    // Transaction-level model: an accepted op answers ALU_LAT+2 cycles later and
    // stays presented until its owner is ready; grants rotate past the last winner.
    task automatic test_random();
        int          last, owner, acc_cyc, g, idx, age;
        bit          idle;
        logic [31:0] ea, eb, eres;
        logic [3:0]  est, exp_r, exp_v;
        apply_reset();
        last = 3; idle = 1'b1; owner = 0; acc_cyc = 0; ea = '0; eb = '0; eres = '0; est = '0;
        for (int c = 0; c < 600; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            req_valid = 4'($urandom) & 4'($urandom | 32'h5);
            rsp_ready = 4'($urandom);
            for (int j = 0; j < 4; j++) begin
                req_a[j*32 +: 32] = $urandom; req_b[j*32 +: 32] = $urandom; req_op[j*2 +: 2] = 2'($urandom);
            end
            @(negedge clk);
            if (idle) begin
                g = -1;
                for (int k = 1; k <= 4; k++) begin
                    idx = (last + k) % 4;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
                exp_r = (g >= 0) ? (4'b0001 << g) : 4'b0000;
                n_checks++; if (req_ready !== exp_r) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, req_ready, exp_r); end
                n_checks++; if ({busy, rsp_valid} !== 5'b0) begin n_fail++; $display("FAIL rnd_idle c%0d: got busy=%b rsp_valid=%b expected 0", c, busy, rsp_valid); end
                if (g >= 0) begin
                    idle = 1'b0; acc_cyc = c; owner = g; last = g;
                    ea = req_a[g*32 +: 32]; eb = req_b[g*32 +: 32];
                    eres = ea ^ eb; est = {2'b00, req_op[g*2 +: 2]};
                end
            end else begin
                age   = c - acc_cyc;
                exp_v = (age >= 3) ? (4'b0001 << owner) : 4'b0000;
                n_checks++; if ({busy, req_ready} !== 5'b10000) begin n_fail++; $display("FAIL rnd_busy c%0d: got busy=%b ready=%b expected 1/0000", c, busy, req_ready); end
                n_checks++; if ({alu_a, alu_b} !== {ea, eb}) begin n_fail++; $display("FAIL rnd_alu_args c%0d: got %h %h expected %h %h", c, alu_a, alu_b, ea, eb); end
                n_checks++; if (rsp_valid !== exp_v) begin n_fail++; $display("FAIL rnd_rsp_valid c%0d: got %b expected %b", c, rsp_valid, exp_v); end
                if (age >= 3) begin
                    n_checks++; if ({rsp_result, rsp_status} !== {eres, est}) begin
                        n_fail++; $display("FAIL rnd_rsp_data c%0d: got %h/%h expected %h/%h", c, rsp_result, rsp_status, eres, est);
                    end
                    if (rsp_ready[owner]) idle = 1'b1;
                end
            end
        end
        req_valid = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_op();
        test_all_four();
        test_backpressure();
        test_reset_in_exec();
        test_single_requester();
        test_lat3();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_arith_unit_arbiter.md
Name: sync_arith_unit_arbiter

Overview:
- Shares one synchronous arithmetic unit between NREQ requesters, using round-robin arbitration and a valid/ready handshake.
- Accepts one operation at a time and drives the ALU operand/op inputs from registers.
- Waits a fixed ALU latency, captures result and status, then returns them to the granted requester with backpressure.
- Sits between requester logic and the ALU (model or gate-level variant); the ALU is external and connected through the o_alu_*/i_alu_* ports.

Parameters:
- BITS, 32, operand/result width; must match the ALU.
- NREQ, 4, number of requesters (2..8).
- ALU_LAT, 1, ALU clock-edge latency from operand sample to result valid (1..4).

Ports:
- i_clk  in  1  clock; all logic is rising-edge.
- i_reset  in  1  synchronous, active-high reset.
- i_req_valid  in  NREQ  per-requester request valid.
- i_req_A  in  NREQ*BITS  operand A; slice k belongs to requester k.
- i_req_B  in  NREQ*BITS  operand B, same packing as i_req_A.
- i_req_op  in  NREQ*2  op code, slice k for requester k.
- o_req_ready  out  NREQ  one-hot accept to the granted requester.
- o_rsp_valid  out  NREQ  one-hot response valid to the owner of the operation.
- i_rsp_ready  in  NREQ  per-requester response ready.
- o_rsp_result  out  BITS  captured ALU result.
- o_rsp_status  out  4  captured ALU status.
- o_alu_arg_A  out  BITS  registered ALU operand A.
- o_alu_arg_B  out  BITS  registered ALU operand B.
- o_alu_op  out  2  registered ALU op code.
- i_alu_result  in  BITS  ALU result.
- i_alu_status  in  4  ALU status.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (i_reset=1 at a rising edge) applies regardless of state:
  - state=IDLE.
  - All outputs 0.
  - RR pointer = NREQ-1, so requester 0 has first priority.
  - Latency counter = 0; any in-flight operation is dropped with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant g = first k with i_req_valid[k]=1, searching from (ptr+1) mod NREQ upward with wrap-around.
  - o_req_ready = one-hot(g), combinational from i_req_valid and ptr; 0 when no request is valid.
  - On acceptance (valid&ready) at a clock edge:
    - latch A/B/op of g into o_alu_*;
    - owner <= g; ptr <= g;
    - counter <= ALU_LAT; state <= EXEC.
- EXEC:
  - o_alu_* hold their values; o_req_ready=0.
  - Counter decrements each edge.
  - On the edge where counter==0: capture i_alu_result/i_alu_status into o_rsp_result/o_rsp_status; state <= RESP.
  - EXEC therefore lasts ALU_LAT+1 cycles.
- RESP:
  - o_rsp_valid[owner]=1, all other bits 0; result and status held stable.
  - Stays in RESP while i_rsp_ready[owner]=0.
  - On i_rsp_ready[owner]=1: state <= IDLE.
  - i_rsp_ready of non-owners is ignored.
- Timing (ALU_LAT=1):
  - accept in cycle 0, EXEC cycles 1-2, o_rsp_valid in cycle 3, next accept earliest cycle 4.
  - Period is ALU_LAT+3 cycles.
- o_alu_* keep the last operation's values in IDLE/RESP. No new acceptance while busy.
- A requester dropping i_req_valid while not granted loses nothing. Valid must not drop while ready is high: it is sampled at the edge only.
- Simultaneous requests resolve strictly round-robin; a requester that keeps valid asserted waits at most NREQ-1 grants.
- Single requester, continuously valid: re-granted every period (pointer wrap lands back on it).
- o_busy = (state != IDLE).

Decomposition:
- Package sync_arith_pkg holds:
  - state enum {IDLE, EXEC, RESP};
  - op code type (logic [1:0]);
  - status width constant STATUS_W=4.
- One sub-module, rr_arbiter (NREQ parameter): inputs req vector and ptr, output one-hot grant plus index. Purely combinational.

Test Plan:
Bench uses a stub ALU with ALU_LAT=1 (registered result = A^B, status = {2'b00, op}), plus a second run against the team ALU model.
1. Reset, then req0 valid with A=32'h0000_00F0, B=32'h0000_000F, op=2 -> o_req_ready=4'b0001 in cycle 0; o_rsp_valid=4'b0001 in cycle 3 with result 32'h0000_00FF and status 4'h2; o_busy high in cycles 1-3.
2. All four valid from reset, rsp_ready held 1 -> grant order 0,1,2,3,0; grants 4 cycles apart.
3. Hold i_rsp_ready[owner]=0 for 5 cycles -> o_rsp_valid and result stable all 5 cycles; no new o_req_ready until 1 cycle after ready rises.
4. Assert i_reset during EXEC (cycle 2) -> next cycle all outputs 0 and state IDLE; no response for the dropped op; next grant goes to req0.
5. Only req2 valid continuously -> granted every 4 cycles; o_req_ready only ever 4'b0100.
6. ALU_LAT=3 build -> o_rsp_valid in cycle 5 after acceptance; result matches the captured model output.
